// File: rtl/cpu_state_core.sv
// cpu_state_core: sequential state of the single-cycle CPU.
// Holds the program counter, the instruction register and a small
// word-addressed data memory with combinational read and synchronous clear.
module cpu_state_core #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] IR_RESET   = 32'h0000_0000,
   parameter int          DMEM_DEPTH = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        is_halt,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   input  logic [31:0] imm_j,
   output logic [31:0] program_counter_value,
   input  logic [31:0] instruction_in,
   output logic [31:0] instruction_out,
   input  logic        memory_we,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data
);

   localparam int AW = $clog2(DMEM_DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_ir;
   logic [31:0]   w_pc_next;
   logic [AW-1:0] w_index;
   logic          w_unused_addr;
   logic [31:0]   r_dmem [DMEM_DEPTH];

   // Word index into the data memory; byte offset and upper bits alias away.
   assign w_index       = address[AW+1:2];
   assign w_unused_addr = ^{address[31:AW+2], address[1:0]};

   // Next-PC selection, first match wins: halt, jal, jalr, branch, sequential.
   always_comb begin
      w_pc_next = r_pc + 32'd4;
      if (is_halt)
         w_pc_next = r_pc;
      else if (is_jal)
         w_pc_next = r_pc + imm_j;
      else if (is_jalr)
         w_pc_next = {jalr_target[31:1], 1'b0};
      else if (branch_taken)
         w_pc_next = branch_target;
   end

   // PC and instruction register; the IR re-latches every cycle, even in halt.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc <= RESET_PC;
         r_ir <= IR_RESET;
      end else begin
         r_pc <= w_pc_next;
         r_ir <= instruction_in;
      end
   end

   // Data memory: reset clears every word and discards a concurrent write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DMEM_DEPTH; i++)
            r_dmem[i] <= 32'h0;
      end else if (memory_we) begin
         r_dmem[w_index] <= write_data;
      end
   end

   assign program_counter_value = r_pc;
   assign instruction_out       = r_ir;
   // Combinational read: shows the old word until the write edge.
   assign read_data             = r_dmem[w_index];

endmodule

// File: tb/tb_cpu_state_core.sv
// Directed testbench for cpu_state_core.
module tb_cpu_state_core;

   logic        clock = 1'b0;
   logic        reset;
   logic        is_halt, is_jal, is_jalr, branch_taken;
   logic [31:0] branch_target, jalr_target, imm_j;
   logic [31:0] program_counter_value;
   logic [31:0] instruction_in, instruction_out;
   logic        memory_we;
   logic [31:0] address, write_data, read_data;

   int n_cmp = 0;
   int n_err = 0;

   cpu_state_core #(
      .RESET_PC  (32'h0),
      .IR_RESET  (32'h0),
      .DMEM_DEPTH(64)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .is_halt              (is_halt),
      .is_jal               (is_jal),
      .is_jalr              (is_jalr),
      .branch_taken         (branch_taken),
      .branch_target        (branch_target),
      .jalr_target          (jalr_target),
      .imm_j                (imm_j),
      .program_counter_value(program_counter_value),
      .instruction_in       (instruction_in),
      .instruction_out      (instruction_out),
      .memory_we            (memory_we),
      .address              (address),
      .write_data           (write_data),
      .read_data            (read_data)
   );

   always #5 clock = ~clock;

   // One rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_ctrl();
      is_halt = 0; is_jal = 0; is_jalr = 0; branch_taken = 0;
      branch_target = 0; jalr_target = 0; imm_j = 0;
   endtask

   // Steer the PC to an arbitrary even address using a JALR.
   task automatic set_pc(input logic [31:0] pc);
      clear_ctrl();
      is_jalr = 1; jalr_target = pc;
      tick();
      clear_ctrl();
      $display("set_pc -> %08h", program_counter_value);
   endtask

   task automatic test_reset();
      logic [31:0] exp_ir;
      reset = 1; instruction_in = 32'h1111_1111;
      tick();
      n_cmp++;
      if (program_counter_value !== 32'h0) begin
         n_err++; $display("FAIL reset_pc got %08h want 00000000", program_counter_value);
      end
      n_cmp++;
      if (instruction_out !== 32'h0) begin
         n_err++; $display("FAIL reset_ir got %08h want 00000000", instruction_out);
      end
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         exp_ir = 32'hA000_0000 | i;
         instruction_in = exp_ir;
         tick();
         $display("seq step %0d pc=%08h ir=%08h", i, program_counter_value, instruction_out);
         n_cmp++;
         if (program_counter_value !== 32'(4 * (i + 1))) begin
            n_err++; $display("FAIL seq_pc got %08h want %08h", program_counter_value, 32'(4 * (i + 1)));
         end
         n_cmp++;
         if (instruction_out !== exp_ir) begin
            n_err++; $display("FAIL seq_ir got %08h want %08h", instruction_out, exp_ir);
         end
      end
   endtask

   task automatic test_halt_jump();
      set_pc(32'd8);
      instruction_in = 32'h0000_0073;
      is_halt = 1; is_jal = 1; imm_j = 32'd100;
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("halt cycle %0d pc=%08h", i, program_counter_value);
         n_cmp++;
         if (program_counter_value !== 32'd8) begin
            n_err++; $display("FAIL halt_pc got %08h want 00000008", program_counter_value);
         end
         n_cmp++;
         if (instruction_out !== 32'h0000_0073) begin
            n_err++; $display("FAIL halt_ir got %08h want 00000073", instruction_out);
         end
      end
      clear_ctrl();
      is_jal = 1; imm_j = 32'hFFFF_FFF8;
      tick();
      $display("jal -8 pc=%08h", program_counter_value);
      n_cmp++;
      if (program_counter_value !== 32'h0) begin
         n_err++; $display("FAIL jal_pc got %08h want 00000000", program_counter_value);
      end
      clear_ctrl();
      is_jalr = 1; jalr_target = 32'h25;
      tick();
      $display("jalr 0x25 pc=%08h", program_counter_value);
      n_cmp++;
      if (program_counter_value !== 32'h24) begin
         n_err++; $display("FAIL jalr_pc got %08h want 00000024", program_counter_value);
      end
      // jal outranks jalr and branch
      clear_ctrl();
      is_jal = 1; imm_j = 32'd4; is_jalr = 1; jalr_target = 32'h100;
      branch_taken = 1; branch_target = 32'h200;
      tick();
      n_cmp++;
      if (program_counter_value !== 32'h28) begin
         n_err++; $display("FAIL jal_prio got %08h want 00000028", program_counter_value);
      end
      // jalr outranks branch
      clear_ctrl();
      is_jalr = 1; jalr_target = 32'h300; branch_taken = 1; branch_target = 32'h200;
      tick();
      n_cmp++;
      if (program_counter_value !== 32'h300) begin
         n_err++; $display("FAIL jalr_prio got %08h want 00000300", program_counter_value);
      end
      clear_ctrl();
   endtask

   task automatic test_branch();
      set_pc(32'd12);
      branch_taken = 1; branch_target = 32'd40;
      tick();
      $display("branch taken pc=%08h", program_counter_value);
      n_cmp++;
      if (program_counter_value !== 32'd40) begin
         n_err++; $display("FAIL br_taken got %08h want 00000028", program_counter_value);
      end
      set_pc(32'd12);
      branch_taken = 0; branch_target = 32'd40;
      tick();
      $display("branch not taken pc=%08h", program_counter_value);
      n_cmp++;
      if (program_counter_value !== 32'd16) begin
         n_err++; $display("FAIL br_not_taken got %08h want 00000010", program_counter_value);
      end
      set_pc(32'hFFFF_FFFC);
      tick();
      $display("wrap pc=%08h", program_counter_value);
      n_cmp++;
      if (program_counter_value !== 32'h0) begin
         n_err++; $display("FAIL pc_wrap got %08h want 00000000", program_counter_value);
      end
   endtask

   task automatic test_dmem();
      memory_we = 1; address = 32'd24; write_data = 32'hDEAD_BEEF;
      tick();
      memory_we = 0;
      $display("write 24 <- deadbeef, read %08h", read_data);
      n_cmp++;
      if (read_data !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL dmem_rd24 got %08h want deadbeef", read_data);
      end
      address = 32'd26; #1;
      n_cmp++;
      if (read_data !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL dmem_rd26 got %08h want deadbeef", read_data);
      end
      address = 32'd280; #1;
      n_cmp++;
      if (read_data !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL dmem_alias got %08h want deadbeef", read_data);
      end
      address = 32'd28; #1;
      n_cmp++;
      if (read_data !== 32'h0) begin
         n_err++; $display("FAIL dmem_rd28 got %08h want 00000000", read_data);
      end
   endtask

   task automatic test_read_during_write();
      memory_we = 1; address = 32'd24; write_data = 32'd5;
      tick();
      write_data = 32'd9; #1;
      $display("rdw before edge read %08h", read_data);
      n_cmp++;
      if (read_data !== 32'd5) begin
         n_err++; $display("FAIL rdw_before got %08h want 00000005", read_data);
      end
      tick();
      memory_we = 0;
      $display("rdw after edge read %08h", read_data);
      n_cmp++;
      if (read_data !== 32'd9) begin
         n_err++; $display("FAIL rdw_after got %08h want 00000009", read_data);
      end
   endtask

   task automatic test_reset_mid();
      set_pc(32'd40);
      instruction_in = 32'h1234_5678;
      memory_we = 1; address = 32'd40; write_data = 32'hCAFE_0001;
      is_halt = 1;
      tick();
      n_cmp++;
      if (program_counter_value !== 32'd40 || instruction_out !== 32'h1234_5678) begin
         n_err++; $display("FAIL pre_reset got pc=%08h ir=%08h want pc=00000028 ir=12345678",
                           program_counter_value, instruction_out);
      end
      clear_ctrl();
      reset = 1; memory_we = 1; address = 32'd24; write_data = 32'h0000_0077;
      tick();
      reset = 0; memory_we = 0;
      $display("mid reset pc=%08h ir=%08h", program_counter_value, instruction_out);
      n_cmp++;
      if (program_counter_value !== 32'h0) begin
         n_err++; $display("FAIL mid_reset_pc got %08h want 00000000", program_counter_value);
      end
      n_cmp++;
      if (instruction_out !== 32'h0) begin
         n_err++; $display("FAIL mid_reset_ir got %08h want 00000000", instruction_out);
      end
      for (int w = 0; w < 64; w++) begin
         address = 32'(w * 4); #0.1;
         n_cmp++;
         if (read_data !== 32'h0) begin
            n_err++; $display("FAIL mid_reset_word%0d got %08h want 00000000", w, read_data);
         end
      end
   endtask

   initial begin
      clear_ctrl();
      reset = 1; instruction_in = 0; memory_we = 0; address = 0; write_data = 0;
      test_reset();
      test_halt_jump();
      test_branch();
      test_dmem();
      test_read_during_write();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
